// File: rtl/framebuffer_pkg.sv
// Shared types and default geometry for the framebuffer drawing engine.
// Provides the command mode enum, the engine state enum and default sizes.
package framebuffer_pkg;

    localparam int H_RES    = 160;
    localparam int V_RES    = 120;
    localparam int FB_DEPTH = 19200;

    typedef enum logic [1:0] {
        MODE_FILL    = 2'd0,
        MODE_OUTLINE = 2'd1,
        MODE_CLEAR   = 2'd2
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DRAW = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/fb_raster_counter.sv
// Raster walker: steps x/y over a rectangle and tracks row_base = y*H_RES.
// Ports: load latches the bounds; step advances one pixel; addr/last out.
module fb_raster_counter #(
    parameter int H_RES      = 160,
    parameter int ADDR_WIDTH = 15,
    parameter int X_WIDTH    = 8,
    parameter int Y_WIDTH    = 7
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  load,
    input  logic                  step,
    input  logic [X_WIDTH-1:0]    x0,
    input  logic [Y_WIDTH-1:0]    y0,
    input  logic [X_WIDTH-1:0]    x1,
    input  logic [Y_WIDTH-1:0]    y1,
    input  logic                  outline,
    input  logic [ADDR_WIDTH-1:0] row_base0,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic                  last
);

    localparam logic [ADDR_WIDTH-1:0] ROW_STEP = ADDR_WIDTH'(H_RES);

    logic [X_WIDTH-1:0]    x_q, x_d, x0_q, x0_d, x1_q, x1_d;
    logic [Y_WIDTH-1:0]    y_q, y_d, y0_q, y0_d, y1_q, y1_d;
    logic [ADDR_WIDTH-1:0] row_q, row_d;
    logic                  outline_q, outline_d;
    logic                  interior;

    assign interior = (y_q != y0_q) && (y_q != y1_q);
    assign last     = (x_q == x1_q) && (y_q == y1_q);
    assign addr     = row_q + ADDR_WIDTH'(x_q);

    always_comb begin
        x_d       = x_q;
        y_d       = y_q;
        row_d     = row_q;
        x0_d      = x0_q;
        x1_d      = x1_q;
        y0_d      = y0_q;
        y1_d      = y1_q;
        outline_d = outline_q;
        if (load) begin
            x_d       = x0;
            y_d       = y0;
            row_d     = row_base0;
            x0_d      = x0;
            x1_d      = x1;
            y0_d      = y0;
            y1_d      = y1;
            outline_d = outline;
        end else if (step && !last) begin
            // Line wrap is tested first so x0==x1 never writes twice.
            if (x_q == x1_q) begin
                x_d   = x0_q;
                y_d   = y_q + 1'b1;
                row_d = row_q + ROW_STEP;
            end else if (outline_q && interior && (x_q == x0_q)) begin
                x_d = x1_q;
            end else begin
                x_d = x_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            x_q       <= '0;
            y_q       <= '0;
            row_q     <= '0;
            x0_q      <= '0;
            x1_q      <= '0;
            y0_q      <= '0;
            y1_q      <= '0;
            outline_q <= 1'b0;
        end else begin
            x_q       <= x_d;
            y_q       <= y_d;
            row_q     <= row_d;
            x0_q      <= x0_d;
            x1_q      <= x1_d;
            y0_q      <= y0_d;
            y1_q      <= y1_d;
            outline_q <= outline_d;
        end
    end

endmodule

// File: rtl/framebuffer_rect_fill.sv
// Rectangle drawing engine: FILL / OUTLINE / CLEAR, one pixel write per cycle.
// Ports: cmd_* handshake in; write_addr/data/we out; busy/done/cmd_error status.
module framebuffer_rect_fill #(
    parameter int H_RES      = framebuffer_pkg::H_RES,
    parameter int V_RES      = framebuffer_pkg::V_RES,
    parameter int DATA_WIDTH = 1,
    parameter int ADDR_WIDTH = 15,
    parameter int X_WIDTH    = 8,
    parameter int Y_WIDTH    = 7
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [1:0]            cmd_mode,
    input  logic [X_WIDTH-1:0]    cmd_x0,
    input  logic [Y_WIDTH-1:0]    cmd_y0,
    input  logic [X_WIDTH-1:0]    cmd_x1,
    input  logic [Y_WIDTH-1:0]    cmd_y1,
    input  logic [DATA_WIDTH-1:0] cmd_color,
    output logic [ADDR_WIDTH-1:0] write_addr,
    output logic [DATA_WIDTH-1:0] data,
    output logic                  we,
    output logic                  busy,
    output logic                  done,
    output logic                  cmd_error
);

    import framebuffer_pkg::*;

    localparam logic [X_WIDTH-1:0] X_MAX = X_WIDTH'(H_RES - 1);
    localparam logic [Y_WIDTH-1:0] Y_MAX = Y_WIDTH'(V_RES - 1);

    state_e                state_q, state_d;
    logic [DATA_WIDTH-1:0] color_q, color_d;
    logic                  err_q, err_d;

    logic                  accept;
    logic                  cmd_ok;
    logic                  outline;
    logic [X_WIDTH-1:0]    x0_c, x1_c;
    logic [Y_WIDTH-1:0]    y0_c, y1_c;
    logic [ADDR_WIDTH-1:0] row_base0;
    logic                  last;

    assign accept = cmd_valid && cmd_ready;

    // Clamp the far corner, then validate; CLEAR replaces the bounds.
    always_comb begin
        x0_c    = cmd_x0;
        y0_c    = cmd_y0;
        x1_c    = (cmd_x1 > X_MAX) ? X_MAX : cmd_x1;
        y1_c    = (cmd_y1 > Y_MAX) ? Y_MAX : cmd_y1;
        outline = 1'b0;
        cmd_ok  = (cmd_x0 <= X_MAX) && (cmd_y0 <= Y_MAX)
                  && (x0_c <= x1_c) && (y0_c <= y1_c);
        case (cmd_mode)
            MODE_FILL: ;
            MODE_OUTLINE: outline = 1'b1;
            MODE_CLEAR: begin
                x0_c   = '0;
                y0_c   = '0;
                x1_c   = X_MAX;
                y1_c   = Y_MAX;
                cmd_ok = 1'b1;
            end
            default: cmd_ok = 1'b0;
        endcase
    end

    // Constant-coefficient multiply, registered by the counter on accept.
    assign row_base0 = ADDR_WIDTH'(y0_c) * ADDR_WIDTH'(H_RES);

    fb_raster_counter #(
        .H_RES      (H_RES),
        .ADDR_WIDTH (ADDR_WIDTH),
        .X_WIDTH    (X_WIDTH),
        .Y_WIDTH    (Y_WIDTH)
    ) u_raster (
        .clock     (clock),
        .reset     (reset),
        .load      (accept),
        .step      (we),
        .x0        (x0_c),
        .y0        (y0_c),
        .x1        (x1_c),
        .y1        (y1_c),
        .outline   (outline),
        .row_base0 (row_base0),
        .addr      (write_addr),
        .last      (last)
    );

    always_comb begin
        color_d = color_q;
        err_d   = err_q;
        if (accept) begin
            color_d = cmd_color;
            err_d   = !cmd_ok;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
            color_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            color_q <= color_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = cmd_ok ? ST_DRAW : ST_DONE;
                end
            end
            ST_DRAW: begin
                if (last) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        cmd_ready = (state_q == ST_IDLE) && !reset;
        we        = (state_q == ST_DRAW);
        busy      = (state_q == ST_DRAW) || (state_q == ST_DONE);
        done      = (state_q == ST_DONE);
        cmd_error = (state_q == ST_DONE) && err_q;
        data      = color_q;
    end

endmodule

// File: tb/tb_framebuffer_rect_fill.sv
// Scoreboard bench for framebuffer_rect_fill with a pixel-set reference model.
// Stimulus pushes expected writes/done events; a negedge monitor checks them.
module tb_framebuffer_rect_fill;

    localparam int H = 160;
    localparam int V = 120;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [1:0]  cmd_mode = '0;
    logic [7:0]  cmd_x0 = '0;
    logic [6:0]  cmd_y0 = '0;
    logic [7:0]  cmd_x1 = '0;
    logic [6:0]  cmd_y1 = '0;
    logic [0:0]  cmd_color = '0;
    logic [14:0] write_addr;
    logic [0:0]  data;
    logic        we;
    logic        busy;
    logic        done;
    logic        cmd_error;

    framebuffer_rect_fill dut (
        .clock      (clock),
        .reset      (reset),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_mode   (cmd_mode),
        .cmd_x0     (cmd_x0),
        .cmd_y0     (cmd_y0),
        .cmd_x1     (cmd_x1),
        .cmd_y1     (cmd_y1),
        .cmd_color  (cmd_color),
        .write_addr (write_addr),
        .data       (data),
        .we         (we),
        .busy       (busy),
        .done       (done),
        .cmd_error  (cmd_error)
    );

    always #5 clock = ~clock;

    typedef struct { int addr; int dat; int cyc; } wr_t;
    typedef struct { int cyc; bit err; } dn_t;

    wr_t wr_q[$];
    dn_t dn_q[$];
    int  checks = 0;
    int  fails = 0;
    int  cyc = 0;
    int  nwr = 0;
    int  ready_at = -1;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input bit ok, input string name,
                       input int act, input int exp);
        checks++;
        if (!ok) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (cyc %0d)",
                     name, act, exp, cyc);
        end
    endtask

    // Reference: a pixel is written if it lies in the clamped rectangle
    // and (for OUTLINE) on its border; raster order, one per cycle.
    task automatic model(input int mode, input int x0, input int y0,
                         input int x1, input int y1, input int color,
                         input int a);
        int n;
        bit rej;
        wr_t w;
        dn_t d;
        n = 0;
        if (x1 >= H) x1 = H - 1;
        if (y1 >= V) y1 = V - 1;
        if (mode == 2) begin
            x0 = 0; y0 = 0; x1 = H - 1; y1 = V - 1;
        end
        rej = (mode == 3) || (mode != 2 &&
              (x0 >= H || y0 >= V || x0 > x1 || y0 > y1));
        if (!rej) begin
            for (int y = y0; y <= y1; y++) begin
                for (int x = x0; x <= x1; x++) begin
                    if (mode != 1 || y == y0 || y == y1 ||
                        x == x0 || x == x1) begin
                        w.addr = y * H + x;
                        w.dat  = color;
                        w.cyc  = a + n;
                        wr_q.push_back(w);
                        n++;
                    end
                end
            end
        end
        d.cyc = a + n;
        d.err = rej;
        dn_q.push_back(d);
    endtask

    always @(negedge clock) begin
        if (!reset) begin
            if (we) begin
                wr_t e;
                nwr++;
                if (wr_q.size() == 0) begin
                    chk(1'b0, "unexpected_write", int'(write_addr), -1);
                end else begin
                    e = wr_q.pop_front();
                    chk(int'(write_addr) == e.addr, "write_addr",
                        int'(write_addr), e.addr);
                    chk(int'(data) == e.dat, "data", int'(data), e.dat);
                    chk(cyc == e.cyc, "write_cycle", cyc, e.cyc);
                    chk(busy == 1'b1, "busy_in_draw", int'(busy), 1);
                end
            end
            if (done) begin
                dn_t d;
                if (dn_q.size() == 0) begin
                    chk(1'b0, "unexpected_done", 1, 0);
                end else begin
                    d = dn_q.pop_front();
                    chk(cyc == d.cyc, "done_cycle", cyc, d.cyc);
                    chk(cmd_error == d.err, "cmd_error",
                        int'(cmd_error), int'(d.err));
                    chk(wr_q.size() == 0, "writes_missing",
                        wr_q.size(), 0);
                    chk(!we && !cmd_ready && busy, "done_outputs",
                        {29'd0, we, cmd_ready, busy}, 1);
                    ready_at = cyc + 1;
                end
            end else if (cmd_error) begin
                chk(1'b0, "error_without_done", 1, 0);
            end
            if (ready_at == cyc) begin
                chk(cmd_ready == 1'b1, "ready_after_done",
                    int'(cmd_ready), 1);
                ready_at = -1;
            end
        end
    end

    task automatic wait_idle();
        int k;
        k = 0;
        while ((dn_q.size() != 0 || ready_at != -1) && k < 30000) begin
            @(negedge clock);
            k++;
        end
        if (k >= 30000) chk(1'b0, "idle_timeout", k, 30000);
    endtask

    task automatic send(input int mode, input int x0, input int y0,
                        input int x1, input int y1, input int color,
                        input int hold, input bit wait_end);
        int k;
        int a;
        @(posedge clock);
        #1;
        cmd_mode  = mode[1:0];
        cmd_x0    = x0[7:0];
        cmd_y0    = y0[6:0];
        cmd_x1    = x1[7:0];
        cmd_y1    = y1[6:0];
        cmd_color = color[0:0];
        cmd_valid = 1'b1;
        k = 0;
        @(negedge clock);
        while (!cmd_ready && k < 1000) begin
            @(negedge clock);
            k++;
        end
        if (k >= 1000) begin
            chk(1'b0, "accept_timeout", k, 1000);
            cmd_valid = 1'b0;
            return;
        end
        @(posedge clock);
        #1;
        a = cyc;
        model(mode & 3, x0 & 255, y0 & 127, x1 & 255, y1 & 127,
              color & 1, a);
        // Garbage on the inputs must not disturb the running command.
        cmd_mode = 2'd2;
        cmd_x0   = 8'($urandom);
        cmd_y0   = 7'($urandom);
        cmd_x1   = 8'($urandom);
        cmd_y1   = 7'($urandom);
        cmd_color = 1'($urandom);
        cmd_valid = (hold > 0);
        repeat (hold) begin
            @(posedge clock);
            #1;
        end
        cmd_valid = 1'b0;
        if (wait_end) wait_idle();
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        int mode, x0, y0, x1, y1;
        repeat (3) @(posedge clock);
        @(negedge clock);
        chk(we == 0 && done == 0 && busy == 0 && cmd_error == 0,
            "reset_status", {28'd0, we, done, busy, cmd_error}, 0);
        chk(write_addr == 0 && data == 0, "reset_addr_data",
            int'(write_addr), 0);
        chk(cmd_ready == 0, "reset_ready", int'(cmd_ready), 0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        @(negedge clock);
        chk(cmd_ready == 1, "ready_after_reset", int'(cmd_ready), 1);

        send(0, 40, 30, 119, 89, 0, 0, 1);
        send(2, 7, 7, 3, 3, 1, 0, 1);
        send(1, 10, 10, 12, 12, 1, 3, 1);
        send(0, 150, 119, 200, 127, 1, 0, 1);
        send(0, 5, 0, 3, 0, 1, 0, 1);
        send(3, 0, 0, 1, 1, 1, 0, 1);
        send(1, 20, 5, 20, 9, 1, 0, 1);
        send(1, 30, 6, 35, 6, 1, 0, 1);
        send(0, 159, 0, 159, 0, 1, 0, 1);
        send(0, 160, 0, 170, 3, 1, 0, 1);

        // Abort mid-draw with a one-cycle reset.
        send(0, 40, 30, 119, 89, 1, 0, 0);
        k = 0;
        while (nwr < 0) k++;
        k = nwr;
        while (nwr < k + 100 && dn_q.size() != 0) @(negedge clock);
        @(posedge clock);
        #1;
        reset = 1'b1;
        @(posedge clock);
        #1;
        wr_q.delete();
        dn_q.delete();
        ready_at = -1;
        @(negedge clock);
        chk(we == 0 && done == 0 && cmd_ready == 0, "abort_outputs",
            {29'd0, we, done, cmd_ready}, 0);
        reset = 1'b0;
        @(negedge clock);
        chk(cmd_ready == 1 && we == 0 && done == 0, "abort_recover",
            {29'd0, cmd_ready, we, done}, 4);
        repeat (5) @(negedge clock);
        send(0, 0, 0, 0, 0, 1, 0, 1);

        for (int i = 0; i < 30; i++) begin
            mode = $urandom_range(0, 3);
            if (mode == 2) mode = 0;
            x0 = $urandom_range(0, 170);
            y0 = $urandom_range(0, 125);
            if ($urandom_range(0, 7) == 0) x1 = $urandom_range(0, 255);
            else x1 = x0 + $urandom_range(0, 12);
            if ($urandom_range(0, 7) == 0) y1 = $urandom_range(0, 127);
            else y1 = y0 + $urandom_range(0, 8);
            send(mode, x0, y0, x1 & 255, y1 & 127,
                 $urandom_range(0, 1), 0, 1);
        end

        repeat (4) @(negedge clock);
        chk(wr_q.size() == 0 && dn_q.size() == 0, "scoreboard_empty",
            wr_q.size() + dn_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 checks, fails);
        $finish;
    end

endmodule
